// File: rtl/motor_cmd_sequencer_pkg.sv
// Shared constants for the motor command sequencer: command-word field
// positions, turn codes and the sequencer state encoding.
package motor_cmd_pkg;

  localparam int TOGGLE_BIT = 7;
  localparam int IDX_MSB    = 6;
  localparam int IDX_LSB    = 4;
  localparam int TURN_MSB   = 3;
  localparam int TURN_LSB   = 2;

  localparam logic [1:0] TURN_NOP   = 2'b00;
  localparam logic [1:0] TURN_CW90  = 2'b01;
  localparam logic [1:0] TURN_180   = 2'b10;
  localparam logic [1:0] TURN_CCW90 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STEP_HI,
    ST_STEP_LO,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/motor_cmd_sequencer_if.sv
// HPS-facing bundle: PIO command word in, stepper driver lines and status out.
interface motor_cmd_sequencer_if #(
  parameter int NUM_MOTORS = 6
);

  logic [7:0]            cmd_word;
  logic [NUM_MOTORS-1:0] step;
  logic [NUM_MOTORS-1:0] dir;
  logic [NUM_MOTORS-1:0] enable_n;
  logic                  busy;
  logic                  done_toggle;
  logic                  err_invalid;
  logic                  err_overrun;

  modport master (
    output cmd_word,
    input  step, dir, enable_n, busy, done_toggle, err_invalid, err_overrun
  );

  modport slave (
    input  cmd_word,
    output step, dir, enable_n, busy, done_toggle, err_invalid, err_overrun
  );

endinterface

// File: rtl/motor_cmd_sequencer_step_timer.sv
// Loadable down-counter; tc_o is high while the count sits at zero.
module step_timer #(
  parameter int W = 8
) (
  input  logic         clk_clk,
  input  logic         reset_reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/motor_cmd_sequencer.sv
// Turns toggle-qualified PIO command words into step/dir pulse trains for one
// of the face steppers, reporting completion via done_toggle and error flags.
//
//   state      | meaning
//   IDLE       | waiting for a toggle change on the registered command word
//   SETUP      | dir/enable applied, waiting DIR_SETUP cycles before first edge
//   STEP_HI    | step line of the selected motor high for a half period
//   STEP_LO    | step line low for a half period, then count one step
//   FINISH     | one cycle after done_toggle flips; new toggles here are overruns
module motor_cmd_sequencer
  import motor_cmd_pkg::*;
#(
  parameter int NUM_MOTORS        = 6,
  parameter int STEPS_PER_QUARTER = 50,
  parameter int STEP_HALF_PERIOD  = 25000,
  parameter int DIR_SETUP         = 250
) (
  input logic                  clk_clk,
  input logic                  reset_reset_n,
  motor_cmd_sequencer_if.slave cmd_if
);

  localparam int CNT_W   = $clog2(2 * STEPS_PER_QUARTER + 1);
  localparam int TMR_MAX = (DIR_SETUP > STEP_HALF_PERIOD) ? DIR_SETUP : STEP_HALF_PERIOD;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(DIR_SETUP - 1);
  localparam logic [TMR_W-1:0] HALF_LOAD  = TMR_W'(STEP_HALF_PERIOD - 1);

  state_t                state_q;
  logic [7:2]            cmd_q;
  logic                  toggle_q;
  logic [NUM_MOTORS-1:0] mask_q;
  logic [CNT_W-1:0]      steps_q;
  logic [NUM_MOTORS-1:0] step_q;
  logic [NUM_MOTORS-1:0] dir_q;
  logic [NUM_MOTORS-1:0] en_n_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_inv_q;
  logic                  err_ovr_q;

  logic                  new_cmd;
  logic [2:0]            cmd_idx;
  logic [1:0]            cmd_turn;
  logic                  idx_valid;
  logic [NUM_MOTORS-1:0] cmd_mask;
  logic [CNT_W-1:0]      cmd_steps;
  logic                  tmr_load;
  logic [TMR_W-1:0]      tmr_val;
  logic                  tmr_tc;
  logic                  unused_rsvd;

  // Reserved command bits are never registered.
  assign unused_rsvd = ^cmd_if.cmd_word[1:0];

  assign new_cmd   = (cmd_q[TOGGLE_BIT] != toggle_q);
  assign cmd_idx   = cmd_q[IDX_MSB:IDX_LSB];
  assign cmd_turn  = cmd_q[TURN_MSB:TURN_LSB];
  assign idx_valid = (int'(cmd_idx) < NUM_MOTORS);
  assign cmd_mask  = NUM_MOTORS'(1) << cmd_idx;

  always_comb begin
    cmd_steps = CNT_W'(STEPS_PER_QUARTER);
    unique case (cmd_turn)
      TURN_NOP: cmd_steps = '0;
      TURN_180: cmd_steps = CNT_W'(2 * STEPS_PER_QUARTER);
      default:  cmd_steps = CNT_W'(STEPS_PER_QUARTER);
    endcase
  end

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = HALF_LOAD;
    unique case (state_q)
      ST_IDLE: begin
        if (new_cmd && idx_valid && (cmd_steps != '0)) begin
          tmr_load = 1'b1;
          tmr_val  = SETUP_LOAD;
        end
      end
      ST_SETUP, ST_STEP_HI, ST_STEP_LO: tmr_load = tmr_tc;
      default: tmr_load = 1'b0;
    endcase
  end

  step_timer #(.W(TMR_W)) u_timer (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .load_i        (tmr_load),
    .load_val_i    (tmr_val),
    .tc_o          (tmr_tc)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      toggle_q  <= 1'b0;
      mask_q    <= '0;
      steps_q   <= '0;
      step_q    <= '0;
      dir_q     <= '0;
      en_n_q    <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_inv_q <= 1'b0;
      err_ovr_q <= 1'b0;
    end else begin
      cmd_q <= cmd_if.cmd_word[7:2];
      if (new_cmd) begin
        toggle_q <= cmd_q[TOGGLE_BIT];
      end
      // Anything outside IDLE, FINISH included, counts as busy for new toggles.
      if (new_cmd && (state_q != ST_IDLE)) begin
        err_ovr_q <= 1'b1;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (new_cmd) begin
            if (!idx_valid) begin
              err_inv_q <= 1'b1;
              done_q    <= ~done_q;
              state_q   <= ST_FINISH;
            end else if (cmd_steps == '0) begin
              err_inv_q <= 1'b0;
              err_ovr_q <= 1'b0;
              done_q    <= ~done_q;
              state_q   <= ST_FINISH;
            end else begin
              mask_q    <= cmd_mask;
              steps_q   <= cmd_steps;
              dir_q     <= (cmd_turn == TURN_CCW90) ? (dir_q & ~cmd_mask) : (dir_q | cmd_mask);
              en_n_q    <= en_n_q & ~cmd_mask;
              busy_q    <= 1'b1;
              err_inv_q <= 1'b0;
              err_ovr_q <= 1'b0;
              state_q   <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          if (tmr_tc) begin
            step_q  <= step_q | mask_q;
            state_q <= ST_STEP_HI;
          end
        end
        ST_STEP_HI: begin
          if (tmr_tc) begin
            step_q  <= step_q & ~mask_q;
            state_q <= ST_STEP_LO;
          end
        end
        ST_STEP_LO: begin
          if (tmr_tc) begin
            steps_q <= steps_q - 1'b1;
            if (steps_q == CNT_W'(1)) begin
              busy_q  <= 1'b0;
              done_q  <= ~done_q;
              en_n_q  <= en_n_q | mask_q;
              state_q <= ST_FINISH;
            end else begin
              step_q  <= step_q | mask_q;
              state_q <= ST_STEP_HI;
            end
          end
        end
        ST_FINISH: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_if.step        = step_q;
  assign cmd_if.dir         = dir_q;
  assign cmd_if.enable_n    = en_n_q;
  assign cmd_if.busy        = busy_q;
  assign cmd_if.done_toggle = done_q;
  assign cmd_if.err_invalid = err_inv_q;
  assign cmd_if.err_overrun = err_ovr_q;

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Bench for motor_cmd_sequencer: directed scenarios with literal expectations,
// then random command traffic, all checked each cycle against a timeline model.
module tb_motor_cmd_sequencer;

  localparam int NM    = 6;
  localparam int SPQ   = 4;
  localparam int HALF  = 2;
  localparam int SETUP = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   chk_en = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  motor_cmd_sequencer_if #(.NUM_MOTORS(NM)) bus ();

  motor_cmd_sequencer #(
    .NUM_MOTORS        (NM),
    .STEPS_PER_QUARTER (SPQ),
    .STEP_HALF_PERIOD  (HALF),
    .DIR_SETUP         (SETUP)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .cmd_if        (bus.slave)
  );

  // Timeline model: a command decoded at edge D with run length T keeps the
  // motor busy for edges D..D+T-1, and done flips at edge D+T.
  int         mn = 0, md = 0, mtot = 0;
  bit         eng = 1'b0, mtog = 1'b0;
  logic [7:0] mcmd = 8'h00;
  logic [NM-1:0] mmask = '0;
  logic [NM-1:0] e_step = '0, e_dir = '0, e_en = '1;
  logic       e_busy = 1'b0, e_done = 1'b0, e_inv = 1'b0, e_ovr = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    bit idle;
    int k, idx, nsteps;
    logic [1:0] turn;
    if (!rst_n) begin
      mn = 0; md = 0; mtot = 0; eng = 0; mtog = 0; mcmd = 8'h00; mmask = '0;
      e_step = '0; e_dir = '0; e_en = '1;
      e_busy = 0; e_done = 0; e_inv = 0; e_ovr = 0;
    end else begin
      mn++;
      idle = !eng || (mn >= md + mtot + 2);
      if (mcmd[7] != mtog) begin
        mtog = mcmd[7];
        if (!idle) begin
          e_ovr = 1'b1;
        end else begin
          idx  = int'(mcmd[6:4]);
          turn = mcmd[3:2];
          eng  = 1'b1;
          md   = mn;
          if (idx >= NM) begin
            e_inv = 1'b1;
            mtot  = 0;
          end else begin
            e_inv  = 1'b0;
            e_ovr  = 1'b0;
            nsteps = (turn == 2'd0) ? 0 : (turn == 2'd2) ? 2 * SPQ : SPQ;
            mtot   = (nsteps == 0) ? 0 : SETUP + 2 * HALF * nsteps;
            mmask  = '0;
            mmask[idx] = 1'b1;
            if (nsteps != 0) e_dir[idx] = (turn != 2'd3);
          end
        end
      end
      mcmd   = bus.cmd_word;
      e_step = '0;
      e_en   = '1;
      e_busy = 1'b0;
      if (eng) begin
        k = mn - md;
        if (k < mtot) begin
          e_busy = 1'b1;
          e_en   = ~mmask;
          if (k >= SETUP && ((k - SETUP) % (2 * HALF)) < HALF) e_step = mmask;
        end
        if (k == mtot) e_done = ~e_done;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if ({bus.step, bus.dir, bus.enable_n, bus.busy, bus.done_toggle, bus.err_invalid, bus.err_overrun}
          !== {e_step, e_dir, e_en, e_busy, e_done, e_inv, e_ovr}) begin
        fails++;
        $display("FAIL cycle_model t=%0t: got step=%b dir=%b en_n=%b busy=%b done=%b inv=%b ovr=%b; expected step=%b dir=%b en_n=%b busy=%b done=%b inv=%b ovr=%b",
                 $time, bus.step, bus.dir, bus.enable_n, bus.busy, bus.done_toggle, bus.err_invalid, bus.err_overrun,
                 e_step, e_dir, e_en, e_busy, e_done, e_inv, e_ovr);
      end
    end
  end

  // Rising-edge counts per motor step line.
  int pc [NM];
  logic [NM-1:0] prev_step = '0;
  initial for (int i = 0; i < NM; i++) pc[i] = 0;
  always @(negedge clk) begin
    for (int i = 0; i < NM; i++) if (bus.step[i] && !prev_step[i]) pc[i]++;
    prev_step = bus.step;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [7:0] w);
    @(negedge clk);
    bus.cmd_word = w;
  endtask

  task automatic wait_done(input string name);
    logic s;
    int i;
    s = bus.done_toggle;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.done_toggle !== s) break;
    end
    tests++;
    if (i >= 200) begin
      fails++;
      $display("FAIL %s: done_toggle did not invert within 200 cycles", name);
    end
  endtask

  int base [NM];
  task automatic snap();
    for (int i = 0; i < NM; i++) base[i] = pc[i];
  endtask

  function automatic int pulses(input int m);
    return pc[m] - base[m];
  endfunction

  initial begin
    logic [7:0] w;
    bit flip, motion;
    int tot, j;
    bus.cmd_word = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset with a zero command word.
    snap();
    repeat (50) @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_enable_n", 32'(bus.enable_n), 32'h3f);
    check("idle_done", 32'(bus.done_toggle), 32'd0);
    tot = 0;
    for (int i = 0; i < NM; i++) tot += pulses(i);
    check("idle_no_steps", 32'(tot), 32'd0);

    // Motor 1, CW90: latency, setup delay, pulse count.
    snap();
    issue(8'h94);
    @(posedge clk); #1;
    check("busy_not_yet", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    check("busy_rise", 32'(bus.busy), 32'd1);
    check("dir1_cw", 32'(bus.dir), 32'h02);
    check("en1_low", 32'(bus.enable_n), 32'h3d);
    repeat (2) @(posedge clk); #1;
    check("setup_no_step", 32'(bus.step), 32'd0);
    @(posedge clk); #1;
    check("first_step_edge", 32'(bus.step), 32'h02);
    wait_done("done_m1");
    check("m1_pulses", 32'(pulses(1)), 32'd4);
    check("m1_done", 32'(bus.done_toggle), 32'd1);
    check("m1_busy_low", 32'(bus.busy), 32'd0);
    check("m1_en_off", 32'(bus.enable_n), 32'h3f);

    // Motor 2, 180 degrees.
    repeat (2) @(negedge clk);
    snap();
    issue(8'h28);
    wait_done("done_m2");
    check("m2_pulses", 32'(pulses(2)), 32'd8);
    check("m2_other_pulses", 32'(pulses(1) + pulses(3)), 32'd0);
    check("m2_dir", 32'(bus.dir), 32'h06);
    check("m2_done", 32'(bus.done_toggle), 32'd0);

    // Motor 3, CCW90 with an overrun write mid-motion.
    repeat (2) @(negedge clk);
    snap();
    issue(8'hBC);
    repeat (8) @(negedge clk);
    issue(8'h3C);
    wait_done("done_m3");
    check("m3_overrun", 32'(bus.err_overrun), 32'd1);
    check("m3_pulses", 32'(pulses(3)), 32'd4);
    check("m3_dir_ccw", 32'(bus.dir), 32'h06);
    repeat (10) @(negedge clk);
    check("m3_single_done", 32'(bus.done_toggle), 32'd1);

    // Invalid motor index, then a NOP that clears the error.
    snap();
    issue(8'h60);
    repeat (5) @(negedge clk);
    check("no_toggle_no_done", 32'(bus.done_toggle), 32'd1);
    issue(8'hF0);
    @(posedge clk); @(posedge clk); #1;
    check("inv_done", 32'(bus.done_toggle), 32'd0);
    check("inv_flag", 32'(bus.err_invalid), 32'd1);
    repeat (5) @(negedge clk);
    tot = 0;
    for (int i = 0; i < NM; i++) tot += pulses(i);
    check("inv_no_steps", 32'(tot), 32'd0);
    issue(8'h00);
    @(posedge clk); @(posedge clk); #1;
    check("nop_done", 32'(bus.done_toggle), 32'd1);
    check("nop_clears_inv", 32'(bus.err_invalid), 32'd0);
    check("nop_clears_ovr", 32'(bus.err_overrun), 32'd0);

    // Reset during STEP_HI, then the same word re-runs after release.
    repeat (3) @(negedge clk);
    issue(8'h94);
    for (j = 0; j < 60; j++) begin
      @(posedge clk); #1;
      if (bus.step[1]) break;
    end
    check("rst_reached_step_hi", 32'(j < 60), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_step", 32'(bus.step), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_enable_n", 32'(bus.enable_n), 32'h3f);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    snap();
    wait_done("done_rerun");
    check("rerun_pulses", 32'(pulses(1)), 32'd4);
    check("rerun_done", 32'(bus.done_toggle), 32'd1);

    // Random traffic, including occasional overrun writes.
    repeat (2) @(negedge clk);
    for (int it = 0; it < 40; it++) begin
      w = 8'($urandom);
      if ($urandom_range(3) != 0) w[7] = ~bus.cmd_word[7];
      flip   = (w[7] != bus.cmd_word[7]);
      motion = flip && (w[6:4] < 3'd6) && (w[3:2] != 2'b00);
      issue(w);
      if (motion && ($urandom_range(3) == 0)) begin
        repeat ($urandom_range(15, 3)) @(negedge clk);
        issue({~w[7], 7'($urandom)});
      end
      if (flip) wait_done("rand_done");
      repeat (2 + $urandom_range(3)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/motor_cmd_sequencer.md
Name: motor_cmd_sequencer

Overview:
- Consumes the 8-bit motor-control command word that the HPS drives through its PIO export.
- Converts each new command into step/direction pulse trains for one of six face stepper drivers of the cube robot.
- Reports completion with a done-toggle and error flags, which the HPS reads back through a PIO input.
- Same clock domain as the PIO; the word is written atomically, so no synchroniser is needed.

Parameters:
- NUM_MOTORS, 6, number of face motors driven.
- STEPS_PER_QUARTER, 50, full steps for a 90° face turn (200-step motor).
- STEP_HALF_PERIOD, 25000, clk_clk cycles per step high and per step low phase (1 kHz at 50 MHz).
- DIR_SETUP, 250, clk_clk cycles between dir/enable change and the first step edge.

Ports:
- clk_clk  in  1  system clock, 50 MHz
- reset_reset_n  in  1  asynchronous active-low reset
- cmd_word  in  8  PIO command: [7] toggle, [6:4] motor index, [3:2] turn code, [1:0] reserved (ignored)
- step  out  NUM_MOTORS  step pulse per motor
- dir  out  NUM_MOTORS  direction per motor, 1 = CW
- enable_n  out  NUM_MOTORS  active-low driver enable per motor
- busy  out  1  high while a command executes
- done_toggle  out  1  inverts once per completed or rejected command
- err_invalid  out  1  sticky until next accepted command: invalid motor index
- err_overrun  out  1  sticky until next accepted command: toggle changed while busy

Behaviour:
- Reset (asynchronous, reset_reset_n low) forces the following values: step=0, dir=0, enable_n=all 1, busy=0, done_toggle=0, err_*=0, FSM=IDLE, counters=0. The toggle history register is loaded with 0.
- Command detection:
  - cmd_word is registered each cycle.
  - A new command exists when registered bit 7 differs from the stored toggle history (toggle_q).
  - toggle_q updates on every detection, including rejected ones.
- Turn codes and step counts:
  - 00 = NOP, 0 steps.
  - 01 = CW 90°, STEPS_PER_QUARTER steps, dir=1.
  - 10 = 180°, 2×STEPS_PER_QUARTER steps, dir=1.
  - 11 = CCW 90°, STEPS_PER_QUARTER steps, dir=0.
  - The step counter width is clog2(2×STEPS_PER_QUARTER+1).
- FSM states: IDLE, SETUP, STEP_HI, STEP_LO, FINISH.
  - IDLE, new command with index ≥ NUM_MOTORS: set err_invalid, no motion, go to FINISH.
  - IDLE, new command with NOP: go to FINISH.
  - IDLE, new valid motion command: latch index and count. Drive dir[idx] and enable_n[idx]=0, clear err_*, set busy=1, go to SETUP.
  - Latency: busy rises 2 cycles after cmd_word changes (1 cycle register, 1 cycle decode).
  - SETUP: wait DIR_SETUP cycles, then go to STEP_HI.
  - STEP_HI: step[idx]=1 for STEP_HALF_PERIOD cycles, then go to STEP_LO.
  - STEP_LO: step[idx]=0 for STEP_HALF_PERIOD cycles, then decrement the remaining count. If zero, go to FINISH; else go to STEP_HI.
  - FINISH (1 cycle): invert done_toggle, set busy=0, set enable_n[idx]=1, go to IDLE.
  - Motors stay disabled between commands; hold torque is not required.
- Only the selected motor's step/dir/enable_n move. All other bits hold their reset values, except that dir keeps its last value.
- Toggle change while busy: set err_overrun and update toggle_q. The command is discarded; the running command is not disturbed.
- Multiple changes during one command still produce a single err_overrun.
- Toggle change in the same cycle as FINISH: treated as busy, so the command is discarded with overrun. The HPS must wait for done_toggle before issuing.
- Reset mid-motion: outputs return to reset values immediately and any step pulse is truncated. After release, toggle_q=0, so a cmd_word with bit 7=1 is treated as a new command.
- Bits [1:0] have no effect.

Decomposition:
- motor_cmd_pkg holds:
  - field position constants (TOGGLE_BIT=7, IDX_MSB=6, IDX_LSB=4, TURN_MSB=3, TURN_LSB=2);
  - turn-code constants (TURN_NOP, TURN_CW90, TURN_180, TURN_CCW90);
  - the FSM state enum.
- One sub-module, step_timer: a loadable down-counter with a terminal-count flag. It is reused for the SETUP wait and the step phase waits.

Test Plan (bench uses STEPS_PER_QUARTER=4, STEP_HALF_PERIOD=2, DIR_SETUP=3):
- Reset release, cmd_word=0x00 -> no busy, enable_n=6'b111111, done_toggle stays 0 for 50 cycles.
- cmd_word=0x94 (toggle=1, motor 1, CW90):
  - busy rises 2 cycles later, dir[1]=1, enable_n[1]=0;
  - first step[1] edge comes 3 cycles after SETUP entry;
  - exactly 4 pulses, each 2 high / 2 low;
  - then done_toggle=1, busy=0, enable_n[1]=1.
- cmd_word=0x28 (toggle=0, motor 2, 180°) -> 8 pulses on step[2] only, dir[2]=1, done_toggle=0.
- cmd_word=0xBC (motor 3, CCW90) -> dir[3]=0, 4 pulses. Mid-motion, write 0x3C -> err_overrun=1, still exactly 4 pulses, one done_toggle inversion.
- cmd_word=0x60 → 0xF0 (toggle 0→1, motor 7, NOP) -> err_invalid=1, no step activity, done_toggle inverts 2 cycles after the write. Then cmd_word=0x00 (toggle back to 0, NOP) -> err_invalid clears and done_toggle inverts again.
- Assert reset_reset_n=0 during STEP_HI of a 0x94 command -> step, busy and enable_n take their reset values in the same cycle. After release with cmd_word still 0x94, the command re-runs with 4 pulses.
